debug_dump_sequencer: RTL and testbench

//  Debug-unit controller that streams a processor resource out over the UART TX byte handshake.
//  On a start pulse it reads one of three sources and sends every 32-bit word as 4 bytes, LSB first:
//   - register bank: all 2^RB_ADDR words
//   - data memory: all 2^DM_ADDR words
//   - PC: one word

---
 rtl/debug_dump_sequencer_pkg.sv | 24 ++
 rtl/debug_dump_sequencer_word_byte_select.sv | 21 ++
 rtl/debug_dump_sequencer.sv | 136 +++++++++++++
 tb/tb_debug_dump_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_sequencer_pkg.sv
// Shared debug-unit definitions: source-select codes, one-hot FSM states and word geometry.
package debug_dump_sequencer_pkg;

  localparam int BYTE_W         = 8;
  localparam int DWORD_W        = 32;
  localparam int BYTES_PER_WORD = DWORD_W / BYTE_W;

  typedef enum logic [1:0] {
    SEL_RB  = 2'b00,
    SEL_DM  = 2'b01,
    SEL_PC  = 2'b10,
    SEL_RSV = 2'b11
  } sel_e;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_FETCH   = 6'b000010,
    S_LATCH   = 6'b000100,
    S_SEND    = 6'b001000,
    S_WAIT_TX = 6'b010000,
    S_DONE    = 6'b100000
  } state_e;

endpackage

// File: rtl/debug_dump_sequencer_word_byte_select.sv
// Combinational byte slice of a word, selected by a 2-bit byte index (index 0 = LSB).
module debug_dump_sequencer_word_byte_select
  import debug_dump_sequencer_pkg::*;
#(
  parameter int BYTE  = 8,
  parameter int DWORD = 32
) (
  input  logic [DWORD-1:0] word,
  input  logic [1:0]       idx,
  output logic [BYTE-1:0]  slice
);

  // Constant-index loop keeps every part-select static.
  always_comb begin
    slice = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (idx == 2'(i)) slice = word[BYTE*i +: BYTE];
    end
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: streams the register bank, data memory or PC out over the UART TX
// byte handshake, one 32-bit word at a time, least significant byte first.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int RB_ADDR = 5,
  parameter int DM_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [1:0]         i_sel,
  output logic               o_rb_rd_en,
  output logic [RB_ADDR-1:0] o_rb_addr,
  input  logic [DWORD-1:0]   i_rb_data,
  output logic               o_dm_rd_en,
  output logic [DM_ADDR-1:0] o_dm_addr,
  input  logic [DWORD-1:0]   i_dm_data,
  input  logic [DWORD-1:0]   i_pc,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [5:0]         o_state
);

  localparam int IDX_W = (RB_ADDR > DM_ADDR) ? RB_ADDR : DM_ADDR;
  localparam logic [IDX_W-1:0] RB_LAST = IDX_W'((2 ** RB_ADDR) - 1);
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'((2 ** DM_ADDR) - 1);

  state_e           state, state_nxt;
  sel_e             sel_q;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] last_idx;
  logic [1:0]       byte_idx;
  logic [DWORD-1:0] word_reg;
  logic             bytes_left;
  logic             words_left;

  always_comb begin
    unique case (sel_q)
      SEL_RB:  last_idx = RB_LAST;
      SEL_DM:  last_idx = DM_LAST;
      default: last_idx = '0;
    endcase
  end

  // Compared before incrementing, so word_idx never wraps past the last word.
  assign bytes_left = (byte_idx != 2'(BYTES_PER_WORD - 1));
  assign words_left = (word_idx < last_idx);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: the default assignment first means no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (i_start) state_nxt = (sel_e'(i_sel) == SEL_RSV) ? S_DONE : S_FETCH;
      S_FETCH:   state_nxt = S_LATCH;
      S_LATCH:   state_nxt = S_SEND;
      S_SEND:    state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (bytes_left)      state_nxt = S_SEND;
          else if (words_left) state_nxt = S_FETCH;
          else                 state_nxt = S_DONE;
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // byte_idx is cleared together with the word load so o_tx_data only moves on entry to SEND.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sel_q    <= SEL_RB;
      word_idx <= '0;
      byte_idx <= '0;
      word_reg <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            sel_q    <= sel_e'(i_sel);
            word_idx <= '0;
          end
        end
        S_LATCH: begin
          byte_idx <= '0;
          unique case (sel_q)
            SEL_RB:  word_reg <= i_rb_data;
            SEL_DM:  word_reg <= i_dm_data;
            default: word_reg <= i_pc;
          endcase
        end
        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (bytes_left)      byte_idx <= byte_idx + 2'd1;
            else if (words_left) word_idx <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  debug_dump_sequencer_word_byte_select #(
    .BYTE  (BYTE),
    .DWORD (DWORD)
  ) u_byte_select (
    .word  (word_reg),
    .idx   (byte_idx),
    .slice (o_tx_data)
  );

  assign o_rb_rd_en = (state == S_FETCH) && (sel_q == SEL_RB);
  assign o_dm_rd_en = (state == S_FETCH) && (sel_q == SEL_DM);
  assign o_rb_addr  = o_rb_rd_en ? word_idx[RB_ADDR-1:0] : '0;
  assign o_dm_addr  = o_dm_rd_en ? word_idx[DM_ADDR-1:0] : '0;

  assign o_tx_start = (state == S_SEND);
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);
  assign o_error    = o_done && (sel_q == SEL_RSV);
  assign o_state    = state;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: reset, RB/DM/PC dumps, reserved select and mid-dump reset.
module tb_debug_dump_sequencer;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_sel   = 2'b00;
  logic        o_rb_rd_en, o_dm_rd_en;
  logic [4:0]  o_rb_addr, o_dm_addr;
  logic [31:0] i_rb_data = '0;
  logic [31:0] i_dm_data = '0;
  logic [31:0] i_pc      = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic        o_busy, o_done, o_error;
  logic [5:0]  o_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rb_mem [32];
  logic [31:0] dm_mem [32];

  // Results of the most recent run_dump call.
  logic [7:0] got [$];
  int  done_cnt, done_cyc, first_tx, last_txdone_cyc, err_stray;
  bit  rd_seen, err_at_done, timed_out;

  always #5 i_clock = ~i_clock;

  debug_dump_sequencer dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_sel      (i_sel),
    .o_rb_rd_en (o_rb_rd_en),
    .o_rb_addr  (o_rb_addr),
    .i_rb_data  (i_rb_data),
    .o_dm_rd_en (o_dm_rd_en),
    .o_dm_addr  (o_dm_addr),
    .i_dm_data  (i_dm_data),
    .i_pc       (i_pc),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_state    (o_state)
  );

  // Synchronous memories with one cycle of read latency.
  always @(posedge i_clock) begin
    if (o_rb_rd_en) i_rb_data <= rb_mem[o_rb_addr];
    if (o_dm_rd_en) i_dm_data <= dm_mem[o_dm_addr];
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [31:0] pack(input int base);
    if (base + 3 >= got.size()) return 32'hxxxx_xxxx;
    return {got[base+3], got[base+2], got[base+1], got[base]};
  endfunction

  // Start a dump and act as the UART (tx_done 4 cycles after each tx_start).
  // Cycle 1 is the cycle right after the edge that samples i_start.
  task automatic run_dump(input logic [1:0] sel, input int abort_at, input bit noise);
    int  cyc = 0;
    int  cd  = 0;
    bit  seen_done = 1'b0;
    got.delete();
    done_cnt = 0; done_cyc = -1; first_tx = -1; last_txdone_cyc = -1; err_stray = 0;
    rd_seen = 1'b0; err_at_done = 1'b0; timed_out = 1'b0;
    i_sel   = sel;
    i_start = 1'b1;
    forever begin
      step();
      cyc++;
      i_start   = 1'b0;
      i_tx_done = 1'b0;
      if (noise) begin
        i_sel = 2'(cyc);
        if (cyc % 97 == 50) i_start = 1'b1;
      end
      if (o_rb_rd_en || o_dm_rd_en) rd_seen = 1'b1;
      if (o_error && !o_done) err_stray++;
      if (o_done) begin
        done_cnt++;
        done_cyc    = cyc;
        err_at_done = o_error;
        seen_done   = 1'b1;
      end
      if (o_tx_start) begin
        got.push_back(o_tx_data);
        if (first_tx < 0) first_tx = cyc;
        cd = 4;
        if (noise) i_tx_done = 1'b1;
        if (got.size() == abort_at) begin
          i_reset = 1'b1;
          step();
          i_reset   = 1'b0;
          i_tx_done = 1'b0;
          check("abort_state", o_state, 6'b000001);
          check("abort_busy", o_busy, 1'b0);
          for (int k = 0; k < 8; k++) begin
            if (o_done || o_tx_start) done_cnt++;
            step();
          end
          break;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_tx_done       = 1'b1;
          last_txdone_cyc = cyc;
        end
      end
      if (seen_done && o_state == 6'b000001) break;
      if (cyc > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
    i_start   = 1'b0;
    i_tx_done = 1'b0;
    i_sel     = 2'b00;
    step();
  endtask

  initial begin
    int bad;
    for (int k = 0; k < 32; k++) begin
      rb_mem[k] = 32'h1000_0000 + 32'(k);
      dm_mem[k] = 32'hC3A5_0000 ^ (32'(k) * 32'h0102_0304);
    end

    // 1. reset held three cycles
    i_reset = 1'b1;
    repeat (3) step();
    i_reset = 1'b0;
    step();
    check("rst_state", o_state, 6'b000001);
    check("rst_tx_start", o_tx_start, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    check("rst_rd_en", {o_rb_rd_en, o_dm_rd_en}, 2'b00);
    check("rst_tx_data", o_tx_data, 8'h00);

    // 2. full register-bank dump
    run_dump(2'b00, -1, 1'b0);
    check("rb_timeout", timed_out, 1'b0);
    check("rb_count", got.size(), 128);
    check("rb_first_word", pack(0), 32'h1000_0000);
    check("rb_last_word", pack(124), 32'h1000_001F);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== rb_mem[i/4][8*(i%4) +: 8]) bad++;
    check("rb_bytes_bad", bad, 0);
    check("rb_done_cnt", done_cnt, 1);
    check("rb_error", err_at_done, 1'b0);
    check("rb_first_tx_cyc", first_tx, 3);
    check("rb_done_cyc", done_cyc, 705);

    // 3. PC dump
    i_pc = 32'hDEAD_BEEF;
    run_dump(2'b10, -1, 1'b0);
    check("pc_count", got.size(), 4);
    check("pc_bytes", pack(0), 32'hDEAD_BEEF);
    check("pc_no_rd_en", rd_seen, 1'b0);
    check("pc_done_after_txdone", done_cyc, last_txdone_cyc + 1);
    check("pc_done_cyc", done_cyc, 23);
    check("pc_done_cnt", done_cnt, 1);

    // 4. data-memory dump with extra starts, stray tx_done in SEND and a wandering i_sel
    run_dump(2'b01, -1, 1'b1);
    check("dm_timeout", timed_out, 1'b0);
    check("dm_count", got.size(), 128);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== dm_mem[i/4][8*(i%4) +: 8]) bad++;
    check("dm_bytes_bad", bad, 0);
    check("dm_done_cnt", done_cnt, 1);
    check("dm_error", err_at_done, 1'b0);

    // 5. reserved select
    run_dump(2'b11, -1, 1'b0);
    check("rsv_done_cyc", done_cyc, 1);
    check("rsv_error", err_at_done, 1'b1);
    check("rsv_count", got.size(), 0);
    check("rsv_err_stray", err_stray, 0);

    // 6. reset after byte 37 of an RB dump, then a clean PC dump
    run_dump(2'b00, 37, 1'b0);
    check("abort_count", got.size(), 37);
    check("abort_no_done", done_cnt, 0);
    i_pc = 32'h0BAD_F00D;
    run_dump(2'b10, -1, 1'b0);
    check("after_abort_bytes", pack(0), 32'h0BAD_F00D);
    check("after_abort_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
